// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults, ABI register indices and the address type for the
// GPR file with pending-write scoreboard.
package gpr_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] addr_t;

    // ABI register indices used by surrounding pipeline logic
    localparam addr_t REG_ZERO = addr_t'(0);
    localparam addr_t REG_A0   = addr_t'(10);
    localparam addr_t REG_A7   = addr_t'(17);

endpackage

// File: rtl/gpr_pend_cnt.sv
// gpr_pend_cnt: saturating up/down pending-write counter for one register.
// clr has priority over inc/dec; simultaneous inc and dec cancel out.
module gpr_pend_cnt #(
    parameter int PCW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           dec,
    input  logic           clr,
    output logic [PCW-1:0] cnt_o
);

    localparam logic [PCW-1:0] CNT_MAX = '1;

    logic [PCW-1:0] cnt_q;
    logic [PCW-1:0] cnt_d;

    // Next-state: clear, count up on a new reservation, down on a release
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gpr_sb.sv
// gpr_sb: XLEN x NREG register file with NRD combinational read ports, one
// writeback port and a per-register pending-write scoreboard.
// Optional macro GPR_SB_BYPASS_EN: same-cycle writeback-to-read forwarding,
// and rd_busy / rsv_ready take the same-cycle release into account.
module gpr_sb
    import gpr_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    parameter  int PCW  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic                wb_err
);

    localparam logic [PCW-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0]  ZERO_A  = AW'(REG_ZERO);

    logic [XLEN-1:0] mem_q [NREG];
    logic [PCW-1:0]  cnt   [NREG];
    logic            wb_hit;
    logic            rsv_hit;
    logic [PCW-1:0]  wb_cnt;
    logic [PCW-1:0]  rsv_cnt;
    logic            wb_err_q;
    logic            wb_err_d;

    // x0 is hardwired: writebacks and reservations to it never take effect
    assign wb_hit  = wb_valid && (wb_addr != ZERO_A);
    assign rsv_hit = rsv_valid && rsv_ready && (rsv_addr != ZERO_A);
    assign wb_cnt  = cnt[wb_addr];
    assign rsv_cnt = cnt[rsv_addr];

    // Register array: writeback port (writes even in a flush cycle)
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is reset because architectural state must read zero after reset.
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_hit) begin
            mem_q[wb_addr] <= wb_data;
        end
    end

    // Pending counters: one per register except x0
    assign cnt[0] = '0;
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic inc_r;
        logic dec_r;
        assign inc_r = rsv_hit && (rsv_addr == AW'(r));
        assign dec_r = wb_hit && (wb_addr == AW'(r)) && (cnt[r] != '0);
        gpr_pend_cnt #(.PCW(PCW)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_r),
            .dec   (dec_r),
            .clr   (flush),
            .cnt_o (cnt[r])
        );
    end

    // Sticky error: release of a register that had nothing outstanding
    assign wb_err_d = wb_err_q || (wb_hit && (wb_cnt == '0) && !flush);

    // Error flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err_q <= 1'b0;
        end else begin
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;

`ifdef GPR_SB_BYPASS_EN
    logic rsv_dec;
    // A saturated register frees a slot if writeback releases it this cycle
    assign rsv_dec   = wb_hit && (wb_addr == rsv_addr) && (rsv_cnt != '0);
    assign rsv_ready = !((rsv_cnt == CNT_MAX) && !rsv_dec);
`else
    assign rsv_ready = (rsv_cnt != CNT_MAX);
`endif

    // Read ports: array data (optionally forwarded) and outstanding-write flag
    always_comb begin
        logic [AW-1:0]  ra;
        logic [PCW-1:0] rc;
        // NOTE: defaults first so no path through this block can infer a latch.
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rc      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr[k*AW +: AW];
            rc = cnt[ra];
`ifdef GPR_SB_BYPASS_EN
            if (!rst && wb_hit && (wb_addr == ra)) begin
                rd_data[k*XLEN +: XLEN] = wb_data;
                rd_busy[k]              = (rc > 1);
            end else begin
                rd_data[k*XLEN +: XLEN] = mem_q[ra];
                rd_busy[k]              = (rc != '0);
            end
`else
            rd_data[k*XLEN +: XLEN] = mem_q[ra];
            rd_busy[k]              = (rc != '0);
`endif
        end
    end

endmodule

// File: doc/gpr_sb.md
Name: gpr_sb

Overview:
- Parametrised successor to the single-issue GPR file: XLEN-wide, NREG-deep register array with NRD combinational read ports and one writeback port.
- Adds a per-register pending-write scoreboard for a pipelined core:
  - decode reserves rd at issue;
  - writeback writes data and releases the reservation;
  - flush drops all reservations.
- Sits between decode (reads/reserve), the writeback stage, and the pipeline-control flush logic.

Parameters:
- XLEN, 32, register width in bits.
- NREG, 32, number of architectural registers (16 for RV32E); power of two, AW = log2(NREG).
- NRD, 2, number of read ports.
- PCW, 2, width of each pending counter; max outstanding writes per register = 2^PCW-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port.
- rd_busy  out  NRD  register still has an outstanding write after this cycle's writeback.
- rsv_valid  in  1  reserve request from decode.
- rsv_addr  in  AW  destination register to reserve.
- rsv_ready  out  1  reservation can be accepted this cycle.
- wb_valid  in  1  writeback valid.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- flush  in  1  clear all pending counters.
- wb_err  out  1  sticky: writeback to a register whose counter was 0.

Behaviour:
- Reset (async, rst=1): all array entries 0, all counters 0, wb_err 0.
  - Outputs during reset: rd_data 0, rd_busy 0, rsv_ready 1.
  - Reset mid-operation discards all state immediately.
- Register x0:
  - reads 0; rd_busy 0;
  - reservations to x0 are accepted (rsv_ready 1) but ignored;
  - writebacks to x0 are ignored and never set wb_err.
- Write: on a posedge with wb_valid=1 and wb_addr!=0, array[wb_addr] <= wb_data.
- Read (combinational, per port k):
  - if bypass is enabled, wb_valid=1 and wb_addr==rd_addr[k]!=0, then rd_data = wb_data;
  - otherwise rd_data = array[rd_addr[k]].
- Pending counter cnt[r] update on each posedge:
  - inc = rsv_valid & rsv_ready & rsv_addr==r & r!=0;
  - dec = wb_valid & wb_addr==r & r!=0 & cnt[r]!=0;
  - cnt[r] <= cnt[r] + inc - dec (inc and dec together: unchanged).
- flush=1 overrides counter updates: all counters <= 0 and the same-cycle reservation is dropped.
  - The same-cycle writeback still writes the array.
- rsv_ready = !(cnt[rsv_addr] == 2^PCW-1 && !dec_on_rsv_addr).
  - Saturated counter stalls decode.
  - Combinational from rsv_addr, wb_*.
- rd_busy[k] = (cnt[rd_addr[k]] - dec_on_that_reg) != 0.
  - A same-cycle reservation is not reflected until the next cycle.
- wb_err is set on a posedge where wb_valid=1, wb_addr!=0 and cnt[wb_addr]==0 (no flush that cycle). It clears only on reset.
- Latency: write visible to reads the next cycle, or the same cycle via bypass. Counter changes are visible the next cycle.

Optional Feature:
- Macro: GPR_SB_BYPASS_EN.
- Defined:
  - same-cycle writeback-to-read forwarding on rd_data;
  - rd_busy accounts for the same-cycle release.
- Undefined:
  - rd_data always comes from the array;
  - rd_busy = cnt[rd_addr[k]] != 0, ignoring the same-cycle writeback;
  - rsv_ready ignores the same-cycle dec (saturated means not ready).

Decomposition:
- Shared package gpr_pkg holds:
  - XLEN/NREG defaults;
  - ABI register index constants (REG_ZERO=0, REG_A0=10, REG_A7=17);
  - the addr_t typedef.
- One sub-module: gpr_pend_cnt.
  - Per-register saturating up/down counter with inc, dec, clr inputs.
  - Instantiated NREG-1 times (x0 has none).

Test Plan:
- Reset: assert rst mid-run after writing x5=0x1234 -> x5 reads 0, all rd_busy 0, wb_err 0, rsv_ready 1.
- Reserve x5, next cycle read x5 -> rd_busy=1. wb x5=0xDEAD while reading x5 -> same cycle rd_data=0xDEAD, rd_busy=0 (BYPASS_EN). Next cycle array holds 0xDEAD.
- Reserve x7 three times (PCW=2) -> cnt=3 and rsv_ready=0 for x7. Same-cycle rsv+wb on x7 -> cnt stays 3. One wb, then rsv_ready=1.
- Reserve x3 and x4, then flush with wb x3=0x11 in the same cycle -> x3=0x11 stored, both busy 0 next cycle, wb_err 0.
- wb x9 with no reservation -> x9 written, wb_err=1 and stays 1 until rst.
- x0: reserve x0 and wb x0=0xFFFF -> x0 reads 0, rd_busy 0, wb_err 0.
